// File: rtl/tape_transport_ctrl.sv
// Cassette transport sequencer: owns the tape position counter and runs the
// stop/play/fast-forward/rewind state machine from one-cycle command pulses.
module tape_transport_ctrl #(
    parameter int POS_W    = 24,
    parameter int PLAY_DIV = 6667,
    parameter int FAST_DIV = 834,
    parameter int LOOP     = 0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             cmd_play,
    input  logic             cmd_stop,
    input  logic             cmd_ff,
    input  logic             cmd_rew,
    input  logic [POS_W-1:0] tape_end,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       state,
    output logic             motor,
    output logic             eot,
    output logic             bot
);

    localparam int MAX_DIV = (PLAY_DIV > FAST_DIV) ? PLAY_DIV : FAST_DIV;
    localparam int DIV_W   = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
    localparam logic [DIV_W-1:0] PLAY_LAST = DIV_W'(PLAY_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_PLAY = 2'd1,
        ST_FFWD = 2'd2,
        ST_REW  = 2'd3
    } st_t;

    st_t              st;
    st_t              cmd_tgt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_last;
    logic             tick;
    logic             over;
    logic             at_end;
    logic             cmd_ok;

    assign state = st;

    always_comb begin
        div_last = (st == ST_PLAY) ? PLAY_LAST : FAST_LAST;
        tick     = (st != ST_STOP) && (div == div_last);
        over     = pos > tape_end;
        at_end   = pos >= tape_end;
        cmd_tgt  = ST_STOP;
        cmd_ok   = 1'b0;
        // Only the highest-priority asserted command is considered; if it is
        // ignored, lower-priority commands in the same cycle are dropped too.
        if (cmd_rew) begin
            cmd_tgt = ST_REW;
            cmd_ok  = (st != ST_REW) && (pos != '0);
        end else if (cmd_ff) begin
            cmd_tgt = ST_FFWD;
            cmd_ok  = (st != ST_FFWD) && !at_end;
        end else if (cmd_play) begin
            cmd_tgt = ST_PLAY;
            cmd_ok  = (st != ST_PLAY) && (!at_end || (LOOP != 0));
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            st    <= ST_STOP;
            pos   <= '0;
            div   <= '0;
            motor <= 1'b0;
            eot   <= 1'b0;
            bot   <= 1'b0;
        end else begin
            eot <= 1'b0;
            bot <= 1'b0;
            if (over)
                pos <= tape_end;
            if (cmd_stop) begin
                if (st != ST_STOP) begin
                    st    <= ST_STOP;
                    motor <= 1'b0;
                    div   <= '0;
                end
            end else if (over) begin
                if (st == ST_PLAY || st == ST_FFWD) begin
                    st    <= ST_STOP;
                    motor <= 1'b0;
                    div   <= '0;
                    eot   <= 1'b1;
                end else if (st == ST_REW) begin
                    div <= tick ? '0 : div + 1'b1;
                end
            end else if (cmd_ok) begin
                st    <= cmd_tgt;
                motor <= 1'b1;
                div   <= '0;
            end else if (tick) begin
                div <= '0;
                case (st)
                    ST_PLAY, ST_FFWD: begin
                        if (pos < tape_end) begin
                            pos <= pos + 1'b1;
                        end else if (st == ST_PLAY && LOOP != 0) begin
                            pos <= '0;
                        end else begin
                            st    <= ST_STOP;
                            motor <= 1'b0;
                            eot   <= 1'b1;
                        end
                    end
                    ST_REW: begin
                        if (pos != '0) begin
                            pos <= pos - 1'b1;
                        end else begin
                            st    <= ST_STOP;
                            motor <= 1'b0;
                            bot   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (st != ST_STOP) begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tape_transport_ctrl.sv
// Directed bench for tape_transport_ctrl: play to end, rewind to start, loop
// mode, command priority, clamp on tape_end drop and asynchronous reset.
module tb_tape_transport_ctrl;

    localparam int POS_W = 24;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             cmd_play, cmd_stop, cmd_ff, cmd_rew;
    logic [POS_W-1:0] tape_end;
    logic [POS_W-1:0] pos, pos_l;
    logic [1:0]       state, state_l;
    logic             motor, motor_l, eot, eot_l, bot, bot_l;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    tape_transport_ctrl #(.POS_W(POS_W), .PLAY_DIV(4), .FAST_DIV(2), .LOOP(0)) dut (
        .clk_sys(clk_sys), .reset(reset), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
        .cmd_ff(cmd_ff), .cmd_rew(cmd_rew), .tape_end(tape_end), .pos(pos),
        .state(state), .motor(motor), .eot(eot), .bot(bot)
    );

    tape_transport_ctrl #(.POS_W(POS_W), .PLAY_DIV(4), .FAST_DIV(2), .LOOP(1)) dut_loop (
        .clk_sys(clk_sys), .reset(reset), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
        .cmd_ff(cmd_ff), .cmd_rew(cmd_rew), .tape_end(tape_end), .pos(pos_l),
        .state(state_l), .motor(motor_l), .eot(eot_l), .bot(bot_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_play = 1'b0; cmd_stop = 1'b0; cmd_ff = 1'b0; cmd_rew = 1'b0;
        tape_end = 24'd5;
        #2;
        check("rst_pos", 32'(pos), 0);
        check("rst_state", 32'(state), 0);
        check("rst_motor", 32'(motor), 0);
        check("rst_eot_bot", {30'd0, eot, bot}, 0);
        cyc(2);
        reset = 1'b0;
        cyc();

        // Play from 0 to tape_end; LOOP instance wraps instead of stopping
        cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
        check("play_state", 32'(state), 1);
        check("play_motor", 32'(motor), 1);
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (k == 3)  check("play_pos_k3", 32'(pos), 0);
            if (k % 4 == 0 && k <= 20) check($sformatf("play_pos_k%0d", k), 32'(pos), 32'(k / 4));
            if (k == 23) check("play_state_k23", 32'(state), 1);
            if (k == 24) begin
                check("eot_state", 32'(state), 0);
                check("eot_pulse", 32'(eot), 1);
                check("eot_pos", 32'(pos), 5);
                check("eot_motor", 32'(motor), 0);
                check("loop_pos", 32'(pos_l), 0);
                check("loop_state", 32'(state_l), 1);
                check("loop_eot", 32'(eot_l), 0);
            end
            if (k == 25) check("eot_one_cycle", 32'(eot), 0);
        end

        cmd_ff = 1'b1; cyc(); cmd_ff = 1'b0;
        check("ff_at_end_ignored", 32'(state), 0);

        // Rewind from 5 down to 0, then bot
        cmd_rew = 1'b1; cyc(); cmd_rew = 1'b0;
        check("rew_state", 32'(state), 3);
        for (int k = 1; k <= 13; k++) begin
            cyc();
            if (k == 1)  check("rew_pos_k1", 32'(pos), 5);
            if (k == 2)  check("rew_pos_k2", 32'(pos), 4);
            if (k == 10) check("rew_pos_k10", 32'(pos), 0);
            if (k == 11) check("rew_state_k11", 32'(state), 3);
            if (k == 12) begin
                check("bot_state", 32'(state), 0);
                check("bot_pulse", 32'(bot), 1);
            end
            if (k == 13) check("bot_one_cycle", 32'(bot), 0);
        end
        cmd_rew = 1'b1; cyc(); cmd_rew = 1'b0;
        check("rew_at_bot_ignored", 32'(state), 0);

        // Redundant play keeps cadence; stop beats ff
        cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
        cyc(2);
        cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
        check("replay_pos", 32'(pos), 0);
        cyc();
        check("replay_cadence", 32'(pos), 1);
        cmd_stop = 1'b1; cmd_ff = 1'b1; cyc(); cmd_stop = 1'b0; cmd_ff = 1'b0;
        check("stop_ff_state", 32'(state), 0);
        check("stop_ff_motor", 32'(motor), 0);
        cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
        cyc(3);
        check("div_cleared_k3", 32'(pos), 1);
        cyc();
        check("div_cleared_k4", 32'(pos), 2);

        // Fast-forward to 4, then drop tape_end below pos
        cmd_ff = 1'b1; cyc(); cmd_ff = 1'b0;
        check("ff_state", 32'(state), 2);
        cyc(2);
        check("ff_pos3", 32'(pos), 3);
        cyc(2);
        check("ff_pos4", 32'(pos), 4);
        tape_end = 24'd2;
        cyc();
        check("clamp_pos", 32'(pos), 2);
        check("clamp_state", 32'(state), 0);
        check("clamp_eot", 32'(eot), 1);

        // Asynchronous reset between edges during FFWD
        tape_end = 24'd5;
        cmd_ff = 1'b1; cyc(); cmd_ff = 1'b0;
        cyc(2);
        check("ff2_pos", 32'(pos), 3);
        #2 reset = 1'b1;
        #1;
        check("arst_pos", 32'(pos), 0);
        check("arst_state", 32'(state), 0);
        check("arst_motor", 32'(motor), 0);
        cyc();
        reset = 1'b0;
        cyc();
        cmd_play = 1'b1; cyc(); cmd_play = 1'b0;
        check("post_rst_play", 32'(state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
